// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: one 32-bit word per frame, fill on miss.
// Optional build macro ICACHE_STATS_EN adds hit_count / miss_count output ports.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t           state;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];
  logic [31:0]      miss_addr;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             fill;
  logic             unused_ok;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:IDX_W+2];

  // Lookups are only honoured in IDLE; during a fill the datapath sees no hit.
  assign hit  = (state == IDLE) && imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
  assign fill = (state == MISS) && !iwait;

  assign ihit      = hit;
  assign imemload  = hit ? data[req_idx] : 32'd0;
  assign iaddr     = miss_addr;
  assign unused_ok = ^imemaddr[1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      iREN      <= 1'b0;
      miss_addr <= 32'd0;
      valid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !hit) begin
            state     <= MISS;
            iREN      <= 1'b1;
            miss_addr <= {imemaddr[31:2], 2'b00};
          end
        end
        MISS: begin
          // The fill runs to completion regardless of what the datapath does meanwhile.
          if (!iwait) begin
            state           <= IDLE;
            iREN            <= 1'b0;
            valid[fill_idx] <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          iREN  <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits alone gate their use.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit)
        hit_count <= hit_count + 32'd1;
      if ((state == IDLE) && imemREN && !hit)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios then random traffic, checked against a
// word-address-level cache model; checks the stats counters when ICACHE_STATS_EN is defined.
module tb_icache;
  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'd0;
  logic        iwait = 1'b0;
  logic [31:0] iload = 32'd0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int tests = 0;
  int fails = 0;

  // Model: which word address each frame holds, plus the outstanding fill.
  bit          mv [SETS];
  logic [31:0] mline [SETS];
  bit          pend;
  logic [31:0] paddr;
  int unsigned mhits;
  int unsigned mmiss;

  icache #(.SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == 32'h0000_0040) return 32'h8C22_0004;
    return w * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend  = 1'b0;
    paddr = 32'd0;
    mhits = 0;
    mmiss = 0;
    for (int i = 0; i < SETS; i++) begin
      mv[i]    = 1'b0;
      mline[i] = 32'd0;
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance model, clock.
  task automatic cyc(input logic ren, input logic [31:0] a, input logic wt);
    logic [31:0] w;
    int          i;
    int          j;
    bit          h;
    imemREN  = ren;
    imemaddr = a;
    iwait    = wt;
    iload    = pend ? memf(paddr) : $urandom;
    #1;
    w = a & 32'hFFFF_FFFC;
    i = int'((w >> 2) & (SETS - 1));
    if (pend) begin
      chk("iREN_miss", iREN, 32'd1);
      chk("iaddr_miss", iaddr, paddr);
      chk("ihit_miss", ihit, 32'd0);
      chk("imemload_miss", imemload, 32'd0);
      if (!wt) begin
        j        = int'((paddr >> 2) & (SETS - 1));
        mv[j]    = 1'b1;
        mline[j] = paddr;
        pend     = 1'b0;
      end
    end else begin
      h = ren && mv[i] && (mline[i] == w);
      chk("iREN_idle", iREN, 32'd0);
      chk("ihit", ihit, h);
      chk("imemload", imemload, h ? memf(w) : 32'd0);
      if (h) mhits++;
      else if (ren) begin
        mmiss++;
        pend  = 1'b1;
        paddr = w;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    logic        r_ren;
    logic        r_wt;
    logic [31:0] r_a;
    model_reset();
    #2;
    chk("rst_ihit", ihit, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iREN", iREN, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Cold miss with zero-wait memory, then warm hit at a different byte offset
    cyc(1'b1, 32'h40, 1'b0);
    cyc(1'b1, 32'h40, 1'b0);
    cyc(1'b1, 32'h40, 1'b0);
    cyc(1'b1, 32'h42, 1'b0);
    cyc(1'b0, 32'h42, 1'b0);
`ifdef ICACHE_STATS_EN
    cyc(1'b1, 32'h80, 1'b0);
    chk("hit_count_plan", hit_count, 32'd2);
    chk("miss_count_plan", miss_count, 32'd2);
`else
    cyc(1'b1, 32'h80, 1'b0);
`endif

    // Conflict eviction: 0x80 replaces 0x40 in frame 0, so 0x40 misses again
    cyc(1'b1, 32'h80, 1'b0);
    cyc(1'b1, 32'h80, 1'b0);
    cyc(1'b1, 32'h40, 1'b0);
    cyc(1'b1, 32'h40, 1'b0);
    cyc(1'b1, 32'h40, 1'b0);

    // Wait states with the request address changing mid-fill
    cyc(1'b1, 32'h100, 1'b1);
    repeat (2) cyc(1'b1, 32'h100, 1'b1);
    repeat (3) cyc(1'b1, 32'h200, 1'b1);
    cyc(1'b1, 32'h200, 1'b0);
    repeat (3) cyc(1'b1, 32'h200, 1'b0);

    // Reset in the middle of a fill clears all frames
    repeat (3) cyc(1'b1, 32'h104, 1'b0);
    cyc(1'b1, 32'h100, 1'b0);
    iwait = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_mid_iREN", iREN, 32'd0);
    chk("rst_mid_ihit", ihit, 32'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    cyc(1'b1, 32'h104, 1'b0);
    cyc(1'b1, 32'h104, 1'b0);
    cyc(1'b1, 32'h104, 1'b0);
    cyc(1'b1, 32'h100, 1'b0);
    cyc(1'b1, 32'h100, 1'b0);
    cyc(1'b1, 32'h100, 1'b0);

    // Random traffic over a small address pool so hits, misses and evictions mix
    repeat (500) begin
      r_ren = ($urandom % 4) != 0;
      r_a   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
      r_wt  = ($urandom % 3) == 0;
      cyc(r_ren, r_a, r_wt);
    end
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, mhits);
    chk("miss_count", miss_count, mmiss);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that sits between the pipeline's instruction-fetch port and the memory controller. It is the responder to the datapath's `imemREN`/`imemaddr` requests on `datapath_cache_if`, returning `ihit`/`imemload`. It is the initiator toward the memory controller on `caches_if`, using `iREN`/`iaddr` and receiving `iwait`/`iload`. It holds one 32-bit word per frame and fills on miss.

## Interface
- `SETS`, default 16: number of frames; power of two, 2..1024. `IDX_W = $clog2(SETS)`. `TAG_W = 30 - IDX_W`.
- `CLK` input 1: clock; all state changes on its rising edge.
- `nRST` input 1: reset, asynchronous, active-low.
- `imemREN` input 1: datapath instruction read request.
- `imemaddr` input 32: byte address of the instruction; bits [1:0] ignored.
- `ihit` output 1: `imemload` is valid this cycle for `imemaddr`.
- `imemload` output 32: instruction word.
- `iREN` output 1: memory read request.
- `iaddr` output 32: memory word address, with bits [1:0] = 0.
- `iwait` input 1: memory busy; the fill completes in the first cycle `iREN` is high and `iwait` is low.
- `iload` input 32: memory read data, valid when `iREN && !iwait`.

## Operation
- Address split: offset = [1:0], index = [IDX_W+1:2], tag = [31:IDX_W+2].
- Each frame stores `valid` (1 bit), `tag` (TAG_W bits) and `data` (32 bits).
- On reset, all `valid` bits clear. Tag and data contents do not need to reset.
- FSM has two states, IDLE and MISS. Reset state is IDLE.
- IDLE behaviour:
  - `hit` = `imemREN` && valid[index] && tag[index] == addr tag.
  - `ihit` = `hit`, combinational.
  - `imemload` = data[index] when `hit`, otherwise 0.
  - If `imemREN` && !`hit`: latch `imemaddr` with [1:0] forced to 0 into `miss_addr`, then go to MISS.
- MISS behaviour:
  - `iREN` = 1, `iaddr` = `miss_addr`, `ihit` = 0, `imemload` = 0.
  - When `iwait` = 0: write valid = 1, tag and data = `iload` into the frame selected by `miss_addr`, then go to IDLE.
- A fill that has started always completes. It is not aborted if `imemREN` drops or `imemaddr` changes.
- After returning to IDLE, hit is re-evaluated against the current `imemaddr`. A changed address can therefore miss again.
- A fill replaces whatever the frame held (direct-mapped eviction). There is no write or invalidate path.

## Timing
- Reset values: `ihit` = 0, `imemload` = 0, `iREN` = 0, `iaddr` = 0, state = IDLE, all valid = 0.
- Hit latency: 0 cycles. `ihit` is asserted in the same cycle as `imemREN` and the matching address.
- Miss latency:
  - Cycle 0: IDLE detects the miss.
  - Cycles 1..N: MISS, where N = number of cycles until `iwait` = 0.
  - Cycle N+1: IDLE, `ihit` = 1.
  - With zero-wait memory, `ihit` arrives 2 cycles after the request.
- `iREN` is high only in MISS. `iaddr` is stable for the entire MISS residency.
- `nRST` low mid-miss: the cache returns to IDLE immediately, `iREN` drops, no frame is written and all valid bits clear.
- When `imemREN` = 0 in IDLE, the cache holds no state change and `ihit` = 0.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds two 32-bit counters: `hit_count`, which increments each IDLE cycle with `hit`, and `miss_count`, which increments on each IDLE→MISS transition.
  - Both counters clear on reset and wrap from 0xFFFFFFFF to 0.
  - Both are exposed as additional output ports of width 32.
- `ICACHE_STATS_EN` not defined: the counters and ports are absent. Functional behaviour is identical.

## Test plan
- Cold miss, zero wait:
  - Stimulus: reset, then `imemREN` = 1, `imemaddr` = 0x00000040, `iwait` = 0, `iload` = 0x8C220004.
  - Required: cycle 1 has `iREN` = 1 and `iaddr` = 0x40. Cycle 2 has `ihit` = 1 and `imemload` = 0x8C220004.
- Warm hit: re-request 0x00000042 after the fill → same-cycle `ihit` = 1 and `imemload` = 0x8C220004. `iREN` stays 0.
- Conflict eviction (SETS = 16):
  - Stimulus: fill 0x00000040 (data A), then request 0x00000080 (same index 0, different tag) with data B.
  - Required: miss and refill. Then 0x40 misses again and `iaddr` = 0x40.
- Wait states and address change mid-miss:
  - Stimulus: miss on 0x100 with `iwait` = 1 for 5 cycles. Change `imemaddr` to 0x200 during the wait.
  - Required: `iaddr` stays 0x100 for 6 cycles, the frame for 0x100 is filled, then 0x200 starts a new miss.
- Reset mid-miss: assert `nRST` = 0 during the MISS state → `iREN` = 0 immediately. After release, 0x100 misses (valid cleared).
- `ICACHE_STATS_EN` build: sequence of miss 0x40, hit 0x40, hit 0x40, miss 0x80 → `hit_count` = 2, `miss_count` = 2.
